// File: rtl/imm_shift_pkg.sv
// imm_shift_pkg: op encodings, FSM state type and small helpers shared by the immediate/shift unit.
package imm_shift_pkg;

  localparam logic [1:0] OP_ZEXT = 2'b00;
  localparam logic [1:0] OP_SEXT = 2'b01;
  localparam logic [1:0] OP_SLL  = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // SRA needs a sign-extended operand so the arithmetic shift brings in the right fill.
  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_SEXT) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/imm_ext.sv
// imm_ext: combinational zero/sign extension of an IMM_W immediate to DATA_W bits, chosen by op.
module imm_ext
  import imm_shift_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] ext
);

  always_comb begin
    if (is_signed_op(op)) begin
      ext = DATA_W'($signed(imm));
    end else begin
      ext = DATA_W'(imm);
    end
  end

endmodule

// File: rtl/imm_shift_unit.sv
// imm_shift_unit: immediate extender plus SLL/SRA shifter with valid/ready handshakes on both sides.
// Define IMM_SHIFT_FAST_EN to perform the whole shift in the accept cycle instead of STEP bits per cycle.
module imm_shift_unit
  import imm_shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int STEP   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IMM_W-1:0]          imm,
  input  logic [1:0]                op,
  input  logic [$clog2(DATA_W)-1:0] shamt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_imm,
  output logic                      busy
);

  localparam int SH_W = $clog2(DATA_W);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q, data_nxt, ext, sra_step;
  logic [SH_W-1:0]   rem_q, rem_nxt, step_amt;
  logic              left_q, left_nxt, is_shift;

  imm_ext #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W)
  ) u_ext (
    .imm(imm),
    .op (op),
    .ext(ext)
  );

  assign is_shift = (op == OP_SLL) || (op == OP_SRA);
  // The last step may be shorter than STEP so the total shift never overshoots shamt.
  assign step_amt = (int'(rem_q) < STEP) ? rem_q : SH_W'(STEP);
  // Kept as a standalone signed expression so the shift stays arithmetic.
  assign sra_step = $signed(data_q) >>> step_amt;
  assign out_imm  = data_q;

`ifdef IMM_SHIFT_FAST_EN
  logic [DATA_W-1:0] sra_full;
  assign sra_full = $signed(ext) >>> shamt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      data_q <= '0;
      rem_q  <= '0;
      left_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
      rem_q  <= rem_nxt;
      left_q <= left_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    rem_nxt   = rem_q;
    left_nxt  = left_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          left_nxt = (op == OP_SLL);
`ifdef IMM_SHIFT_FAST_EN
          if (op == OP_SLL) begin
            data_nxt = ext << shamt;
          end else if (op == OP_SRA) begin
            data_nxt = sra_full;
          end else begin
            data_nxt = ext;
          end
          rem_nxt   = '0;
          state_nxt = ST_DONE;
`else
          data_nxt  = ext;
          rem_nxt   = is_shift ? shamt : '0;
          state_nxt = (is_shift && (shamt != '0)) ? ST_SHIFT : ST_DONE;
`endif
        end
      end
      ST_SHIFT: begin
        data_nxt = left_q ? (data_q << step_amt) : sra_step;
        rem_nxt  = rem_q - step_amt;
        if (rem_nxt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imm_shift_unit.sv
// Bench for imm_shift_unit: a STEP=1 and a STEP=4 instance receive the same request stream.
module tb_imm_shift_unit;

  localparam logic [1:0] ZEXT = 2'b00;
  localparam logic [1:0] SEXT = 2'b01;
  localparam logic [1:0] SLL  = 2'b10;
  localparam logic [1:0] SRA  = 2'b11;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] imm;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic        rdy1, vld1, busy1, rdy4, vld4, busy4;
  logic [31:0] res1, res4;

  int          total = 0;
  int          bad   = 0;

  int          lat1, lat4;
  logic [31:0] val1, val4;
  logic        held1, held4, busy_ok, idle_ok;

  always #5 clk = ~clk;

  imm_shift_unit #(.DATA_W(32), .IMM_W(16), .STEP(1)) u_step1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .imm(imm), .op(op),
    .shamt(shamt), .out_valid(vld1), .out_ready(out_ready), .out_imm(res1), .busy(busy1)
  );

  imm_shift_unit #(.DATA_W(32), .IMM_W(16), .STEP(4)) u_step4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .imm(imm), .op(op),
    .shamt(shamt), .out_valid(vld4), .out_ready(out_ready), .out_imm(res4), .busy(busy4)
  );

  // Result as plain arithmetic: extend to an integer, multiply or floor-divide by 2**shamt, keep 32 bits.
  function automatic logic [31:0] model_result(input logic [15:0] a, input logic [1:0] o,
                                               input logic [4:0] s);
    longint v, p, r;
    v = longint'(a);
    if ((o == SEXT || o == SRA) && a[15]) v = v - 65536;
    p = 1;
    repeat (int'(s)) p = p * 2;
    case (o)
      SLL:     r = v * p;
      SRA:     r = (v >= 0) ? (v / p) : -((-v + p - 1) / p);
      default: r = v;
    endcase
    return r[31:0];
  endfunction

  function automatic int model_latency(input logic [1:0] o, input logic [4:0] s, input int step);
    int n;
    n = int'(s);
`ifdef IMM_SHIFT_FAST_EN
    n = 0;
`endif
    if (o == ZEXT || o == SEXT || n == 0) return 1;
    return 1 + (n + step - 1) / step;
  endfunction

  // Issues one request at the current negedge, keeps out_ready low for `hold` cycles after both
  // instances are valid, then completes the handshake; leaves the bench at a negedge.
  task automatic applyStimulus(input logic [15:0] a, input logic [1:0] o, input logic [4:0] s,
                               input int hold);
    int cyc;
    int held_cnt;
    imm = a; op = o; shamt = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat1 = 0; lat4 = 0; held1 = 1'b1; held4 = 1'b1; busy_ok = 1'b1;
    cyc = 1; held_cnt = 0;
    forever begin
      in_valid = 1'b1; imm = 16'($urandom); op = 2'($urandom); shamt = 5'($urandom);
      if (rdy1 !== 1'b0 || rdy4 !== 1'b0 || busy1 !== 1'b1 || busy4 !== 1'b1) busy_ok = 1'b0;
      if (lat1 != 0) begin
        if (vld1 !== 1'b1 || res1 !== val1) held1 = 1'b0;
      end else if (vld1 === 1'b1) begin
        lat1 = cyc; val1 = res1;
      end
      if (lat4 != 0) begin
        if (vld4 !== 1'b1 || res4 !== val4) held4 = 1'b0;
      end else if (vld4 === 1'b1) begin
        lat4 = cyc; val4 = res4;
      end
      if (lat1 != 0 && lat4 != 0) begin
        if (held_cnt >= hold) break;
        held_cnt++;
      end
      if (cyc >= 80) break;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    idle_ok = (rdy1 === 1'b1) && (rdy4 === 1'b1) && (vld1 === 1'b0) && (vld4 === 1'b0) &&
              (busy1 === 1'b0) && (busy4 === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; imm = '0; op = '0; shamt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_in_ready: got %b/%b expected 1/1", rdy1, rdy4);
    end
    total++; if (vld1 !== 1'b0 || vld4 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_out_valid: got %b/%b expected 0/0", vld1, vld4);
    end
    total++; if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_busy: got %b/%b expected 0/0", busy1, busy4);
    end
    total++; if (res1 !== 32'h0 || res4 !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_out_imm: got %h/%h expected 0/0", res1, res4);
    end
    rst = 1'b0;
  endtask

  task automatic test_ext();
    applyStimulus(16'h8001, SEXT, 5'd9, 0);
    total++; if (val1 !== 32'hFFFF8001 || val4 !== 32'hFFFF8001) begin
      bad++; $display("[TB] FAIL sext_value: got %h/%h expected ffff8001", val1, val4);
    end
    total++; if (lat1 !== 1 || lat4 !== 1) begin
      bad++; $display("[TB] FAIL sext_latency: got %0d/%0d expected 1/1", lat1, lat4);
    end
    applyStimulus(16'h8001, ZEXT, 5'd3, 1);
    total++; if (val1 !== 32'h00008001 || val4 !== 32'h00008001) begin
      bad++; $display("[TB] FAIL zext_value: got %h/%h expected 00008001", val1, val4);
    end
    total++; if (lat1 !== 1 || lat4 !== 1 || !idle_ok) begin
      bad++; $display("[TB] FAIL zext_latency: got %0d/%0d idle=%b expected 1/1 idle=1",
                      lat1, lat4, idle_ok);
    end
  endtask

  task automatic test_sll_lui();
    applyStimulus(16'h1234, SLL, 5'd16, 0);
    total++; if (val1 !== 32'h12340000 || val4 !== 32'h12340000) begin
      bad++; $display("[TB] FAIL lui_value: got %h/%h expected 12340000", val1, val4);
    end
    total++; if (lat1 !== model_latency(SLL, 5'd16, 1) || lat4 !== model_latency(SLL, 5'd16, 4)) begin
      bad++; $display("[TB] FAIL lui_latency: got %0d/%0d expected %0d/%0d", lat1, lat4,
                      model_latency(SLL, 5'd16, 1), model_latency(SLL, 5'd16, 4));
    end
  endtask

  task automatic test_sra_step4();
    applyStimulus(16'h8000, SRA, 5'd4, 0);
    total++; if (val1 !== 32'hFFFFF800 || val4 !== 32'hFFFFF800) begin
      bad++; $display("[TB] FAIL sra_value: got %h/%h expected fffff800", val1, val4);
    end
    total++; if (lat4 !== model_latency(SRA, 5'd4, 4) || lat1 !== model_latency(SRA, 5'd4, 1)) begin
      bad++; $display("[TB] FAIL sra_latency: got %0d/%0d expected %0d/%0d", lat1, lat4,
                      model_latency(SRA, 5'd4, 1), model_latency(SRA, 5'd4, 4));
    end
  endtask

  task automatic test_hold();
    applyStimulus(16'h0001, SLL, 5'd31, 5);
    total++; if (val4 !== 32'h80000000 || val1 !== 32'h80000000) begin
      bad++; $display("[TB] FAIL hold_value: got %h/%h expected 80000000", val1, val4);
    end
    total++; if (lat4 !== model_latency(SLL, 5'd31, 4)) begin
      bad++; $display("[TB] FAIL hold_latency: got %0d expected %0d", lat4, model_latency(SLL, 5'd31, 4));
    end
    total++; if (!held1 || !held4) begin
      bad++; $display("[TB] FAIL hold_stable: got %b/%b expected 1/1", held1, held4);
    end
    total++; if (!busy_ok || !idle_ok) begin
      bad++; $display("[TB] FAIL hold_in_ready: got busy_ok=%b idle_ok=%b expected 1/1", busy_ok, idle_ok);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic stray;
    imm = 16'h00F0; op = SLL; shamt = 5'd20; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++; if (vld1 !== 1'b0 || vld4 !== 1'b0 || res1 !== 32'h0 || res4 !== 32'h0) begin
      bad++; $display("[TB] FAIL abort_outputs: got valid %b/%b imm %h/%h expected 0/0 0/0",
                      vld1, vld4, res1, res4);
    end
    total++; if (rdy1 !== 1'b1 || rdy4 !== 1'b1 || busy1 !== 1'b0 || busy4 !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_idle: got ready %b/%b busy %b/%b expected 1/1 0/0",
                      rdy1, rdy4, busy1, busy4);
    end
    stray = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (vld1 !== 1'b0 || vld4 !== 1'b0) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_no_result: got stray=%b expected 0", stray);
    end
    applyStimulus(16'hABCD, SRA, 5'd7, 0);
    total++; if (val1 !== model_result(16'hABCD, SRA, 5'd7) || val4 !== model_result(16'hABCD, SRA, 5'd7)) begin
      bad++; $display("[TB] FAIL after_abort_value: got %h/%h expected %h", val1, val4,
                      model_result(16'hABCD, SRA, 5'd7));
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(16'hF00F, SEXT, 5'd0, 0);
    total++; if (val1 !== 32'hFFFFF00F || !idle_ok) begin
      bad++; $display("[TB] FAIL b2b_first: got %h idle=%b expected fffff00f idle=1", val1, idle_ok);
    end
    applyStimulus(16'h7FFF, SLL, 5'd0, 0);
    total++; if (val4 !== 32'h00007FFF || lat4 !== 1) begin
      bad++; $display("[TB] FAIL b2b_second: got %h lat %0d expected 00007fff lat 1", val4, lat4);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [1:0]  o;
    logic [4:0]  s;
    logic [31:0] exp_v;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom); o = 2'($urandom); s = 5'($urandom);
      exp_v = model_result(a, o, s);
      applyStimulus(a, o, s, $urandom_range(0, 3));
      total++; if (val1 !== exp_v || val4 !== exp_v) begin
        bad++; $display("[TB] FAIL rand_value op=%0d imm=%h sh=%0d: got %h/%h expected %h",
                        o, a, s, val1, val4, exp_v);
      end
      total++; if (lat1 !== model_latency(o, s, 1) || lat4 !== model_latency(o, s, 4)) begin
        bad++; $display("[TB] FAIL rand_latency op=%0d sh=%0d: got %0d/%0d expected %0d/%0d",
                        o, s, lat1, lat4, model_latency(o, s, 1), model_latency(o, s, 4));
      end
      total++; if (!held1 || !held4 || !busy_ok || !idle_ok) begin
        bad++; $display("[TB] FAIL rand_handshake: got held %b/%b busy_ok %b idle_ok %b expected all 1",
                        held1, held4, busy_ok, idle_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ext();
    test_sll_lui();
    test_sra_step4();
    test_hold();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
